// File: rtl/tmds_symbol_decoder.sv
// Purpose : decode one TMDS lane (raw 10-bit gearbox words) into 8-bit pixel data or
//           C1/C0 control bits, recovering word alignment with a bit-slip search.
// Latency : 2 clk_pixel cycles from the 10-bit window to the registered outputs; no backpressure.
//
// Ports:
//   clk_pixel    pixel clock, one raw 10-bit word per cycle
//   resetn       synchronous active-low reset
//   in_word      raw unaligned deserialized bits, bit 0 = earliest received
//   out_data     decoded pixel byte (held during control periods)
//   out_de       1 = out_data is video data, 0 = control period
//   out_c        {C1,C0} of the last control token (held during video)
//   out_locked   word alignment locked
//   out_offset   current bit-slip offset 0..9
//   out_loss_cnt saturating count of lock losses (only with TMDS_LOCK_LOSS_CNT_EN)
//
// Build option: define TMDS_LOCK_LOSS_CNT_EN to add out_loss_cnt.

module tmds_symbol_decoder #(
    parameter int C_LOCK_RUN = 32,   // consecutive tokens needed to declare lock (2..255)
    parameter int C_TIMEOUT  = 4096  // cycles without a qualifying run before slip / unlock
) (
    input  logic       clk_pixel,
    input  logic       resetn,
    input  logic [9:0] in_word,
    output logic [7:0] out_data,
    output logic       out_de,
    output logic [1:0] out_c,
    output logic       out_locked,
    output logic [3:0] out_offset
`ifdef TMDS_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] out_loss_cnt
`endif
);

    localparam logic [7:0]  LOCK_RUN = 8'(C_LOCK_RUN);
    localparam logic [15:0] TO_LAST  = 16'(C_TIMEOUT - 1);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t      state;
    logic [9:0]  prev;
    logic [9:0]  q_win;
    logic        tok;
    logic [1:0]  code;

    logic [9:0]  q1;
    logic        tok1;
    logic [1:0]  code1;

    logic [7:0]  run;
    logic [7:0]  run_nxt;
    logic        run_done;
    logic [15:0] timeout;
    logic        timeout_hit;
    logic [3:0]  offset_wrap;

`ifdef TMDS_LOCK_LOSS_CNT_EN
    logic [7:0]  loss_cnt;
    assign out_loss_cnt = loss_cnt;
`endif

    // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] o;
        d    = s[9] ? ~s[7:0] : s[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    // The 20-bit window always contains one complete symbol at some offset 0..9;
    // prev holds the older (earlier received) bits in the low half.
    assign q_win = 10'({in_word, prev} >> out_offset);

    always_comb begin
        tok  = 1'b1;
        code = 2'b00;
        case (q_win)
            10'b1101010100: code = 2'b00;
            10'b0010101011: code = 2'b01;
            10'b0101010100: code = 2'b10;
            10'b1010101011: code = 2'b11;
            default:        tok  = 1'b0;
        endcase
    end

    // Run length of consecutive stage-1 tokens, saturating at the lock threshold.
    // Once saturated, every further token keeps run_done high, which is what holds
    // the timeout at zero during long blanking periods.
    assign run_nxt     = tok1 ? ((run == LOCK_RUN) ? run : run + 8'd1) : 8'd0;
    assign run_done    = (run_nxt == LOCK_RUN);
    assign timeout_hit = (timeout == TO_LAST);
    assign offset_wrap = (out_offset == 4'd9) ? 4'd0 : out_offset + 4'd1;

    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            state      <= SEARCH;
            prev       <= '0;
            q1         <= '0;
            tok1       <= 1'b0;
            code1      <= 2'b00;
            run        <= '0;
            timeout    <= '0;
            out_data   <= '0;
            out_de     <= 1'b0;
            out_c      <= 2'b00;
            out_locked <= 1'b0;
            out_offset <= '0;
`ifdef TMDS_LOCK_LOSS_CNT_EN
            loss_cnt   <= '0;
`endif
        end else begin
            prev  <= in_word;

            // Stage 1: aligned symbol and its token classification.
            q1    <= q_win;
            tok1  <= tok;
            code1 <= code;

            // Stage 2: each output field holds while the other kind of symbol flows.
            if (tok1) begin
                out_de <= 1'b0;
                out_c  <= code1;
            end else begin
                out_de   <= 1'b1;
                out_data <= tmds_decode(q1);
            end

            // Alignment FSM. A run completion always beats a timeout in the same cycle.
            case (state)
                SEARCH: begin
                    if (run_done) begin
                        state      <= LOCKED;
                        out_locked <= 1'b1;
                        timeout    <= '0;
                        run        <= run_nxt;
                    end else if (timeout_hit) begin
                        // Slip one bit; the symbol in stage 1 now does not count.
                        out_offset <= offset_wrap;
                        run        <= '0;
                        timeout    <= '0;
                    end else begin
                        timeout <= timeout + 16'd1;
                        run     <= run_nxt;
                    end
                end
                LOCKED: begin
                    if (run_done) begin
                        timeout <= '0;
                        run     <= run_nxt;
                    end else if (timeout_hit) begin
                        // Offset is kept so a transient re-locks on the first search pass.
                        state      <= SEARCH;
                        out_locked <= 1'b0;
                        run        <= '0;
                        timeout    <= '0;
`ifdef TMDS_LOCK_LOSS_CNT_EN
                        if (loss_cnt != 8'hFF) begin
                            loss_cnt <= loss_cnt + 8'd1;
                        end
`endif
                    end else begin
                        timeout <= timeout + 16'd1;
                        run     <= run_nxt;
                    end
                end
            endcase
        end
    end

endmodule
